// File: rtl/rmii_receive_frame_buffer_if.sv
// Signal bundle between the RMII receive MAC, the receive frame buffer and the
// core data orchestrator. The slave modport is the buffer's view of the bundle.
interface rmii_receive_frame_buffer_if #(
  parameter int unsigned DEPTH = 2048
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [7:0]    receive_byte;
  logic          receive_byte_valid;
  logic          receive_frame_end;
  logic          receive_frame_error;
  logic          port_receive_data_ready;
  logic [8:0]    port_recieve_data;
  logic          port_recieve_data_enable;
  logic [PW-1:0] frames_pending;
  logic [15:0]   dropped_frame_count;

  modport master (
    output receive_byte, receive_byte_valid, receive_frame_end, receive_frame_error,
    output port_receive_data_ready,
    input  port_recieve_data, port_recieve_data_enable, frames_pending, dropped_frame_count
  );

  modport slave (
    input  receive_byte, receive_byte_valid, receive_frame_end, receive_frame_error,
    input  port_receive_data_ready,
    output port_recieve_data, port_recieve_data_enable, frames_pending, dropped_frame_count
  );
endinterface

// File: rtl/rmii_receive_frame_buffer.sv
// Per-port RMII receive frame buffer: stores frame bytes, commits clean frames,
// rolls back bad ones, and streams committed frames out as {last, byte} words.
module rmii_receive_frame_buffer #(
  parameter int unsigned DEPTH           = 2048,
  parameter int unsigned MAX_FRAME_BYTES = 1522,
  parameter int unsigned MIN_FRAME_BYTES = 64
) (
  input logic                        clock,
  input logic                        reset,
  rmii_receive_frame_buffer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] PtrOne = PW'(1);
  localparam logic [10:0]   LenMax = 11'(MAX_FRAME_BYTES);
  localparam logic [10:0]   LenMin = 11'(MIN_FRAME_BYTES);

  typedef enum logic [1:0] {WIdle, WReceive, WDiscard} wstate_e;

  logic [8:0]    mem [DEPTH];
  wstate_e       wstate_q, wstate_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]    stage_q, stage_d;
  logic [10:0]   len_q, len_d;
  logic [PW-1:0] pending_q, pending_d;
  logic [15:0]   dropped_q, dropped_d;
  logic [8:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          mem_we, commit, full, xfer, load;
  logic [8:0]    mem_wdata;

  assign full = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

  // Write side: the staging register delays each byte by one so the final byte
  // can be written with last=1 when the frame end arrives.
  always_comb begin
    wstate_d     = wstate_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    stage_d      = stage_q;
    len_d        = len_q;
    dropped_d    = dropped_q;
    mem_we       = 1'b0;
    mem_wdata    = {1'b0, stage_q};
    commit       = 1'b0;
    unique case (wstate_q)
      WIdle: begin
        if (bus.receive_byte_valid) begin
          stage_d  = bus.receive_byte;
          len_d    = 11'd1;
          wstate_d = WReceive;
        end
      end
      WReceive: begin
        if (bus.receive_byte_valid) begin
          if (full || len_q >= LenMax) begin
            wr_ptr_d = commit_ptr_q;
            wstate_d = WDiscard;
          end else begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + PtrOne;
            stage_d  = bus.receive_byte;
            len_d    = (len_q == 11'h7FF) ? len_q : len_q + 11'd1;
          end
        end else if (bus.receive_frame_end) begin
          wstate_d = WIdle;
          if (!bus.receive_frame_error && len_q >= LenMin && len_q <= LenMax && !full) begin
            mem_we       = 1'b1;
            mem_wdata    = {1'b1, stage_q};
            wr_ptr_d     = wr_ptr_q + PtrOne;
            commit_ptr_d = wr_ptr_q + PtrOne;
            commit       = 1'b1;
          end else begin
            wr_ptr_d  = commit_ptr_q;
            dropped_d = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
          end
        end
      end
      WDiscard: begin
        if (bus.receive_frame_end) begin
          dropped_d = (dropped_q == 16'hFFFF) ? dropped_q : dropped_q + 16'd1;
          wstate_d  = WIdle;
        end
      end
      default: wstate_d = WIdle;
    endcase
  end

  // Read side: single output register refilled in the same cycle it drains.
  always_comb begin
    xfer        = out_valid_q & bus.port_receive_data_ready;
    load        = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || xfer);
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_ptr_d    = rd_ptr_q;
    if (load) begin
      out_data_d  = mem[rd_ptr_q[AW-1:0]];
      out_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PtrOne;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    pending_d = pending_q;
    case ({commit, xfer & out_data_q[8]})
      2'b10:   pending_d = pending_q + PtrOne;
      2'b01:   pending_d = pending_q - PtrOne;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wstate_q     <= WIdle;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      stage_q      <= '0;
      len_q        <= '0;
      pending_q    <= '0;
      dropped_q    <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      wstate_q     <= wstate_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      stage_q      <= stage_d;
      len_q        <= len_d;
      pending_q    <= pending_d;
      dropped_q    <= dropped_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) begin
      mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

  assign bus.port_recieve_data        = out_data_q;
  assign bus.port_recieve_data_enable = out_valid_q;
  assign bus.frames_pending           = pending_q;
  assign bus.dropped_frame_count      = dropped_q;
endmodule

// File: tb/tb_rmii_receive_frame_buffer.sv
// Directed bench for rmii_receive_frame_buffer: a full-size instance plus a
// 128-entry instance for the overflow case, selected by sel.
module tb_rmii_receive_frame_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = '0;
  logic       rx_valid = 1'b0, rx_end = 1'b0, rx_err = 1'b0, ready = 1'b0, sel = 1'b0;
  int         tests = 0, fails = 0, en_cycles = 0, used = 0;
  logic [8:0] got[$];

  always #5 clk = ~clk;

  rmii_receive_frame_buffer_if #(.DEPTH(2048)) ifa ();
  rmii_receive_frame_buffer_if #(.DEPTH(128))  ifb ();

  assign ifa.receive_byte            = rx_byte;
  assign ifa.receive_byte_valid      = rx_valid & ~sel;
  assign ifa.receive_frame_end       = rx_end & ~sel;
  assign ifa.receive_frame_error     = rx_err;
  assign ifa.port_receive_data_ready = ready & ~sel;
  assign ifb.receive_byte            = rx_byte;
  assign ifb.receive_byte_valid      = rx_valid & sel;
  assign ifb.receive_frame_end       = rx_end & sel;
  assign ifb.receive_frame_error     = rx_err;
  assign ifb.port_receive_data_ready = ready & sel;

  rmii_receive_frame_buffer #(
    .DEPTH(2048), .MAX_FRAME_BYTES(1522), .MIN_FRAME_BYTES(64)
  ) dut (
    .clock(clk), .reset(rst), .bus(ifa.slave)
  );

  rmii_receive_frame_buffer #(
    .DEPTH(128), .MAX_FRAME_BYTES(120), .MIN_FRAME_BYTES(64)
  ) dut_small (
    .clock(clk), .reset(rst), .bus(ifb.slave)
  );

  logic [8:0]  obs_data;
  logic        obs_en;
  logic [11:0] obs_pending;
  logic [15:0] obs_dropped;
  assign obs_data    = sel ? ifb.port_recieve_data : ifa.port_recieve_data;
  assign obs_en      = sel ? ifb.port_recieve_data_enable : ifa.port_recieve_data_enable;
  assign obs_pending = sel ? 12'(ifb.frames_pending) : ifa.frames_pending;
  assign obs_dropped = sel ? ifb.dropped_frame_count : ifa.dropped_frame_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (obs_en) en_cycles++;
  endtask

  task automatic send_bytes(input logic [7:0] start, input int len);
    for (int i = 0; i < len; i++) begin
      rx_valid = 1'b1;
      rx_byte  = start + 8'(i);
      tick();
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_end(input logic err);
    rx_end = 1'b1;
    rx_err = err;
    tick();
    rx_end = 1'b0;
    rx_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] start, input int len, input logic err);
    send_bytes(start, len);
    send_end(err);
  endtask

  task automatic collect(input int n, input int budget, input bit toggle, output int cycles);
    int cyc = 0;
    bit hold = 1'b0;
    logic [8:0] held = '0;
    got.delete();
    while (got.size() < n && cyc < budget) begin
      if (hold) check("hold_while_not_ready", {22'd0, obs_en, obs_data}, {22'd0, 1'b1, held});
      ready = toggle ? ~cyc[0] : 1'b1;
      hold  = toggle && obs_en && !ready;
      held  = obs_data;
      if (obs_en && ready) got.push_back(obs_data);
      tick();
      cyc++;
    end
    cycles = cyc;
    check("word_count", 32'(got.size()), 32'(n));
  endtask

  task automatic check_frame(input int base, input int len, input logic [7:0] start,
                             input string tag);
    logic [8:0] exp;
    for (int i = 0; i < len; i++) begin
      exp[8]   = (i == len - 1);
      exp[7:0] = start + 8'(i);
      if (base + i < got.size()) check(tag, 32'(got[base+i]), 32'(exp));
      else check(tag, 32'h1FFFF, 32'(exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    check("reset_data", 32'(obs_data), 32'h0);
    check("reset_enable", 32'(obs_en), 32'h0);
    check("reset_pending", 32'(obs_pending), 32'h0);
    check("reset_dropped", 32'(obs_dropped), 32'h0);
    rst = 1'b0;
    tick();

    // Good 64-byte frame, ready held high.
    ready = 1'b1;
    send_frame(8'h00, 64, 1'b0);
    check("t1_pending_k1", 32'(obs_pending), 32'd1);
    check("t1_enable_k1", 32'(obs_en), 32'd0);
    tick();
    check("t1_enable_k2", 32'(obs_en), 32'd1);
    check("t1_first_word", 32'(obs_data), 32'h000);
    collect(64, 200, 1'b0, used);
    check("t1_zero_bubble_cycles", 32'(used), 32'd64);
    check_frame(0, 64, 8'h00, "t1_word");
    check("t1_pending_done", 32'(obs_pending), 32'd0);

    // Errored frame dropped, then a good frame delivered intact.
    en_cycles = 0;
    send_frame(8'h10, 64, 1'b1);
    check("t2_dropped", 32'(obs_dropped), 32'd1);
    repeat (3) tick();
    check("t2_no_enable", 32'(en_cycles), 32'd0);
    check("t2_pending", 32'(obs_pending), 32'd0);
    send_frame(8'h80, 70, 1'b0);
    collect(70, 200, 1'b0, used);
    check_frame(0, 70, 8'h80, "t2_word");

    // Runt and oversize frames both dropped; a maximum-length frame is kept.
    en_cycles = 0;
    send_frame(8'h00, 63, 1'b0);
    send_frame(8'h00, 1523, 1'b0);
    repeat (4) tick();
    check("t3_dropped", 32'(obs_dropped), 32'd3);
    check("t3_no_enable", 32'(en_cycles), 32'd0);
    check("t3_pending", 32'(obs_pending), 32'd0);
    send_frame(8'h05, 1522, 1'b0);
    check("t3_max_pending", 32'(obs_pending), 32'd1);
    collect(1522, 1600, 1'b0, used);
    check_frame(0, 1522, 8'h05, "t3_max_word");

    // Ready toggling every cycle during a 100-byte read.
    ready = 1'b0;
    send_frame(8'h20, 100, 1'b0);
    tick();
    check("t5_enable", 32'(obs_en), 32'd1);
    check("t5_pending", 32'(obs_pending), 32'd1);
    collect(100, 400, 1'b1, used);
    check_frame(0, 100, 8'h20, "t5_word");
    check("t5_pending_done", 32'(obs_pending), 32'd0);

    // Reset mid-read and mid-frame discards everything buffered.
    ready = 1'b0;
    send_frame(8'h40, 64, 1'b0);
    tick();
    check("t6_pre_enable", 32'(obs_en), 32'd1);
    send_bytes(8'h00, 29);
    rx_valid = 1'b1;
    rx_byte  = 8'd29;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    rx_valid = 1'b0;
    check("t6_rst_data", 32'(obs_data), 32'h0);
    check("t6_rst_enable", 32'(obs_en), 32'd0);
    check("t6_rst_pending", 32'(obs_pending), 32'd0);
    check("t6_rst_dropped", 32'(obs_dropped), 32'd0);
    en_cycles = 0;
    send_frame(8'd30, 34, 1'b0);
    repeat (3) tick();
    check("t6_tail_dropped", 32'(obs_dropped), 32'd1);
    check("t6_tail_no_enable", 32'(en_cycles), 32'd0);
    check("t6_tail_pending", 32'(obs_pending), 32'd0);
    ready = 1'b1;
    send_frame(8'h90, 64, 1'b0);
    collect(64, 200, 1'b0, used);
    check_frame(0, 64, 8'h90, "t6_word");

    // 128-entry buffer: two frames fit, the third overflows.
    sel   = 1'b1;
    ready = 1'b0;
    tick();
    send_frame(8'h00, 64, 1'b0);
    send_frame(8'h40, 64, 1'b0);
    send_frame(8'hC0, 64, 1'b0);
    tick();
    check("t4_pending", 32'(obs_pending), 32'd2);
    check("t4_dropped", 32'(obs_dropped), 32'd1);
    check("t4_enable", 32'(obs_en), 32'd1);
    collect(128, 300, 1'b0, used);
    check_frame(0, 64, 8'h00, "t4_frame1");
    check_frame(64, 64, 8'h40, "t4_frame2");
    repeat (3) tick();
    check("t4_drained_enable", 32'(obs_en), 32'd0);
    check("t4_drained_pending", 32'(obs_pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
